// File: rtl/wave_pkg.sv
// Shared types and widths for the wave buffer controller and its posted-write FIFO.
package wave_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  // FIFO entry layout: {bank, addr, data}
  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    StFill    = 2'b00,
    StDrain   = 2'b01,
    StPending = 2'b10
  } ctrl_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic              bank,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {bank, addr, data};
  endfunction

endpackage

// File: rtl/dffr.sv
// Enabled register with asynchronous active-high reset to zero.
module dffr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wave_wr_fifo.sv
// Posted-write FIFO for capture samples; push and pop may coincide even when full.
module wave_wr_fifo
  import wave_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               empty,
  output logic               drop
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               full, push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  dffr #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (push_ok),
    .d     (wr_ptr_q + PTR_W'(1)),
    .q     (wr_ptr_q)
  );

  dffr #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (pop_ok),
    .d     (rd_ptr_q + PTR_W'(1)),
    .q     (rd_ptr_q)
  );

  dffr #(.WIDTH(CNT_W)) u_count (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (count_d),
    .q     (count_q)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    dffr #(.WIDTH(ENTRY_W)) u_entry (
      .clk   (clk),
      .reset (reset),
      .en    (push_ok && (wr_ptr_q == PTR_W'(i))),
      .d     (push_data),
      .q     (mem_q[i])
    );
  end

endmodule

// File: rtl/wave_buffer_ctrl.sv
// Double-buffered sample RAM controller: capture fills one bank through a posted-write
// FIFO while the display reads the other; banks swap on vsync once the fill has drained.
module wave_buffer_ctrl
  import wave_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_frame_done,
  input  logic              disp_rd,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_vsync,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              read_bank,
  output logic              capture_idle,
  output logic              overflow
);

  ctrl_state_e        state_q, state_d;
  logic               read_bank_q, overflow_q, disp_valid_q, swap_q, capture_idle_q;
  logic               push, pop, swap, cap_drop;
  logic               fifo_empty, fifo_drop;
  logic [ENTRY_W-1:0] fifo_head;

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    cap_drop = 1'b0;
    swap     = 1'b0;
    unique case (state_q)
      StFill: begin
        push = cap_we;
        if (cap_frame_done) state_d = StDrain;
      end
      StDrain: begin
        cap_drop = cap_we;
        if (fifo_empty) state_d = StPending;
      end
      StPending: begin
        cap_drop = cap_we;
        if (disp_vsync) begin
          swap    = 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Display reads own the RAM port; the FIFO drains only in idle read cycles.
  assign pop       = ~disp_rd & ~fifo_empty;
  assign ram_we    = pop & ~reset;
  assign ram_addr  = disp_rd ? {read_bank_q, disp_addr} : fifo_head[ENTRY_W-1:DATA_W];
  assign ram_wdata = fifo_head[DATA_W-1:0];

  assign disp_data    = ram_rdata;
  assign disp_valid   = disp_valid_q;
  assign read_bank    = read_bank_q;
  assign capture_idle = capture_idle_q;
  assign overflow     = overflow_q;

  wave_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pack_entry(~read_bank_q, cap_addr, cap_data)),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StFill;
      read_bank_q    <= 1'b0;
      overflow_q     <= 1'b0;
      disp_valid_q   <= 1'b0;
      swap_q         <= 1'b0;
      capture_idle_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      if (swap) read_bank_q <= ~read_bank_q;
      overflow_q     <= overflow_q | cap_drop | fifo_drop;
      disp_valid_q   <= disp_rd;
      // capture_idle trails the bank toggle by one cycle
      swap_q         <= swap;
      capture_idle_q <= swap_q;
    end
  end

endmodule

// File: tb/tb_wave_buffer_ctrl.sv
// Directed self-checking bench for wave_buffer_ctrl with a behavioural single-port RAM.
module tb_wave_buffer_ctrl;

  logic       clk, reset;
  logic       cap_we, cap_frame_done, disp_rd, disp_vsync;
  logic [7:0] cap_addr, cap_data, disp_addr;
  logic       ram_we, disp_valid, read_bank, capture_idle, overflow;
  logic [8:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata, disp_data;

  logic [7:0]  mem [512];
  logic [16:0] wlog [$];
  int          n_checks, n_errors, conflicts, we_in_reset, bad;

  wave_buffer_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .cap_we         (cap_we),
    .cap_addr       (cap_addr),
    .cap_data       (cap_data),
    .cap_frame_done (cap_frame_done),
    .disp_rd        (disp_rd),
    .disp_addr      (disp_addr),
    .disp_vsync     (disp_vsync),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .disp_data      (disp_data),
    .disp_valid     (disp_valid),
    .read_bank      (read_bank),
    .capture_idle   (capture_idle),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model and write log
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wlog.push_back({ram_addr, ram_wdata});
    end else begin
      ram_rdata <= mem[ram_addr];
    end
    if (ram_we && disp_rd) conflicts <= conflicts + 1;
    if (ram_we && reset) we_in_reset <= we_in_reset + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; conflicts = 0; we_in_reset = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h007] = 8'hA5;
    ram_rdata = 8'h00;
    reset = 1'b1;
    cap_we = 0; cap_addr = 0; cap_data = 0; cap_frame_done = 0;
    disp_rd = 0; disp_addr = 0; disp_vsync = 0;
    repeat (2) @(negedge clk);
    #1 check("rst_ram_we", ram_we, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_read_bank", read_bank, 0);
    check("rst_overflow", overflow, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_capture_idle", capture_idle, 0);

    // Scenario 6: vsync in FILL is ignored
    disp_vsync = 1;
    @(negedge clk);
    disp_vsync = 0;
    check("s6_bank", read_bank, 0);
    check("s6_idle0", capture_idle, 0);
    @(negedge clk);
    check("s6_idle1", capture_idle, 0);
    @(negedge clk);
    check("s6_idle2", capture_idle, 0);
    check("s6_bank2", read_bank, 0);

    // Scenario 1: full frame into bank 1
    wlog.delete();
    for (int i = 0; i < 256; i++) begin
      cap_we = 1; cap_addr = i[7:0]; cap_data = i[7:0]; cap_frame_done = (i == 255);
      @(negedge clk);
    end
    cap_we = 0; cap_frame_done = 0;
    for (int k = 0; k < 400 && wlog.size() < 256; k++) @(negedge clk);
    check("s1_count", wlog.size(), 256);
    bad = 0;
    for (int j = 0; j < 256 && j < wlog.size(); j++) begin
      if (wlog[j] !== {1'b1, j[7:0], j[7:0]}) bad++;
    end
    check("s1_order", bad, 0);
    repeat (3) @(negedge clk);
    check("s1_count_stable", wlog.size(), 256);
    check("s1_bank_pre", read_bank, 0);
    check("s1_overflow", overflow, 0);

    // Scenario 4: swap in PENDING with a coincident read of index 7
    disp_vsync = 1; disp_rd = 1; disp_addr = 8'd7;
    #1;
    check("s4_addr", ram_addr, 9'h007);
    check("s4_we", ram_we, 0);
    @(negedge clk);
    disp_vsync = 0; disp_rd = 0;
    check("s4_valid", disp_valid, 1);
    check("s4_data", disp_data, 8'hA5);
    check("s4_bank", read_bank, 1);
    check("s4_idle_early", capture_idle, 0);
    @(negedge clk);
    check("s4_idle", capture_idle, 1);
    check("s4_valid_off", disp_valid, 0);
    @(negedge clk);
    check("s4_idle_off", capture_idle, 0);

    // Scenario 2: reads block the drain; three writes follow in order
    wlog.delete();
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        check("s2_rd_valid", disp_valid, 1);
        check("s2_rd_data", disp_data, 8'h05);
      end
      disp_rd = 1; disp_addr = 8'h05;
      cap_we = (c < 3); cap_addr = 8'h10 + c[7:0]; cap_data = 8'hC0 + c[7:0];
      @(negedge clk);
    end
    disp_rd = 0; cap_we = 0;
    check("s2_no_write_during_rd", wlog.size(), 0);
    repeat (6) @(negedge clk);
    check("s2_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("s2_w0", wlog[0], {9'h010, 8'hC0});
      check("s2_w1", wlog[1], {9'h011, 8'hC1});
      check("s2_w2", wlog[2], {9'h012, 8'hC2});
    end
    check("s2_overflow", overflow, 0);
    check("s2_conflicts", conflicts, 0);

    // Scenario 3: five pushes into a depth-4 FIFO while reads hold the port
    wlog.delete();
    for (int c = 0; c < 5; c++) begin
      if (c == 4) check("s3_ovf_before", overflow, 0);
      disp_rd = 1; disp_addr = 8'h00;
      cap_we = 1; cap_addr = 8'h20 + c[7:0]; cap_data = 8'hD0 + c[7:0];
      @(negedge clk);
    end
    cap_we = 0;
    check("s3_overflow", overflow, 1);
    check("s3_no_write", wlog.size(), 0);
    disp_rd = 0;
    repeat (8) @(negedge clk);
    check("s3_count", wlog.size(), 4);
    bad = 0;
    for (int j = 0; j < 4 && j < wlog.size(); j++) begin
      if (wlog[j] !== {1'b0, 8'h20 + j[7:0], 8'hD0 + j[7:0]}) bad++;
    end
    check("s3_order", bad, 0);
    check("s3_ovf_sticky", overflow, 1);

    // Scenario 5: reset discards queued entries
    wlog.delete();
    for (int c = 0; c < 2; c++) begin
      disp_rd = 1; cap_we = 1; cap_addr = 8'h30 + c[7:0]; cap_data = 8'hE0 + c[7:0];
      @(negedge clk);
    end
    cap_we = 0; disp_rd = 0; reset = 1;
    #1 check("s5_we_in_reset", ram_we, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    check("s5_no_write", wlog.size(), 0);
    check("s5_bank", read_bank, 0);
    check("s5_overflow", overflow, 0);
    check("s5_we_reset_cnt", we_in_reset, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
